serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller: sequences one shared full-adder cell over WIDTH-bit operands, LSB first.
//  Accepts an operand pair via valid/ready, runs WIDTH add cycles, presents the result via valid/ready.
//  This is the area-minimal add path: one 1-bit cell plus shift registers instead of a WIDTH-bit ripple chain.
// PARAMETERS
//  WIDTH   8   operand/result width in bits, >=1
// PORTS
//  clk        in   1      sole clock, all state changes on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair offered
//  in_ready   out  1      controller will accept operands this cycle
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  cin        in   1      carry-in for the LSB
//  out_valid  out  1      result held and valid
//  out_ready  in   1      consumer takes result this cycle
//  sum        out  WIDTH  op_a+op_b+cin, low WIDTH bits
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset: state=IDLE; sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 in the cycle after reset deasserts.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. in_valid -> latch op_a/op_b into shift regs A/B, carry reg=cin, bit cnt=0, go RUN.
//   RUN : in_ready=0, out_valid=0. Each cycle: cell computes s,c from A[0],B[0],carry;
//         s shifts into sum MSB (sum shifts right), A/B shift right, carry<=c, cnt++.
//         On the cycle cnt==WIDTH-1: capture final c into cout, ovf=carry_in_of_MSB ^ c, go DONE.
//   DONE: out_valid=1, sum/cout/ovf stable. out_ready -> IDLE, unless in_valid also high (below).
//  Latency: accept edge to out_valid = WIDTH+1 cycles; RUN lasts exactly WIDTH cycles.
//  Throughput: in_ready = IDLE | (DONE & out_ready). If in DONE out_ready & in_valid same cycle: result
//   retired and new operands latched on that edge, go directly RUN (no IDLE bubble). Max one op per WIDTH+1 cycles.
//  Operands sampled only on the accept edge; op_a/op_b/cin changes afterward have no effect.
//  in_valid while busy (RUN, or DONE without out_ready) ignored; producer must hold it (AXI-style, not dropped).
//  out_valid never drops without out_ready; sum/cout/ovf must not change while out_valid=1.
//  sum is internal working register; its value during RUN is don't-care to the consumer.
//  Counter width max(1,$clog2(WIDTH)); no wrap occurs since cnt reset at each accept.
//  WIDTH=1: RUN lasts one cycle; ovf = cin ^ cout.
//  rst mid-RUN or in DONE: operation abandoned, result discarded, all outputs to reset values next edge.
//  Arithmetic is unsigned modulo 2^WIDTH; cout and ovf let consumer interpret unsigned/signed.
// STRUCTURE
//  Package serial_add_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default WIDTH constant.
//  One sub-module: the team's 1-bit full-adder cell (a,b,c -> sum,carry), instantiated once as the datapath.
//  Remainder in this file: FSM, bit counter, A/B/sum shift regs, carry reg, output flags.
//  Unused state encoding 2'd3 decodes to IDLE.
// TESTING (WIDTH=8 unless stated)
//  1. 0x3C+0x05,cin=0 -> out_valid exactly 9 cycles after accept; sum=0x41,cout=0,ovf=0.
//  2. 0xFF+0x01,cin=0 -> sum=0x00,cout=1,ovf=0; 0x7F+0x01 -> sum=0x80,cout=0,ovf=1; 0x80+0x80 -> sum=0x00,cout=1,ovf=1.
//  3. 0xFF+0xFF,cin=1 -> sum=0xFF,cout=1; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
//  4. Back-to-back: in_valid held with 2nd pair 0x10+0x20 while DONE & out_ready -> no IDLE cycle, 2nd result 0x30.
//  5. rst asserted at RUN cycle 4 -> next cycle out_valid=0, sum=0, in_ready=1; fresh 0x01+0x01 -> 0x02.
//  6. WIDTH=1: 1+1,cin=1 -> sum=1,cout=1,ovf=0, 2 cycles latency; plus 10k random ops vs golden a+b+cin model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell, the only arithmetic element of the serial add path.
module serial_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  // Plain combinational full adder: sum bit and carry out from three inputs.
  always_comb begin
    sum   = a ^ b ^ c_in;
    carry = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell is stepped across the
// operands LSB first, one bit per clock, with valid/ready on both sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cell_sum;
  logic             cell_carry;
  logic             accept;

  serial_add_ctrl_fa u_cell (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  // Handshake decode; the unused encoding behaves like IDLE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      RUN: begin
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  assign accept = in_valid & in_ready;

  // Next-state logic: accept operands, step the cell once per RUN cycle, hold results in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      state_d = RUN;
      a_d     = op_a;
      b_d     = op_b;
      carry_d = cin;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          sum_d            = sum_q >> 1;
          sum_d[WIDTH-1]   = cell_sum;
          a_d              = a_q >> 1;
          b_d              = b_q >> 1;
          carry_d          = cell_carry;
          if (cnt_q == LAST_BIT) begin
            cout_d  = cell_carry;
            ovf_d   = carry_q ^ cell_carry;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
